// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-requester round-robin arbiter driving a strobed memory bus
//               with ready handshake, timeout abort and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 rw0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic                 req1,
  input  logic                 rw1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic                 err0,
  output logic                 err1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rw,
  output logic                 mem_strb_n,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_data_oe,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_rdy_n
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_STROBE = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_last;

  logic                 w_pick1;
  logic                 w_sel_rw;
  logic [ADDR_SIZE-1:0] w_sel_addr;
  logic [WORD_SIZE-1:0] w_sel_wdata;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last
  assign w_pick1     = req1 & (~req0 | ~r_last);
  assign w_sel_rw    = w_pick1 ? rw1    : rw0;
  assign w_sel_addr  = w_pick1 ? addr1  : addr0;
  assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;
  assign w_cnt_inc   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_rw      <= 1'b1;
      mem_strb_n  <= 1'b1;
      mem_wdata   <= '0;
      mem_data_oe <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (req0 || req1) begin
            mem_addr    <= w_sel_addr;
            mem_rw      <= w_sel_rw;
            mem_wdata   <= w_sel_wdata;
            mem_data_oe <= ~w_sel_rw;
            mem_strb_n  <= 1'b0;
            gnt0        <= ~w_pick1;
            gnt1        <= w_pick1;
            r_state     <= c_STROBE;
          end
        end
        c_STROBE: begin
          mem_strb_n <= 1'b1;
          r_cnt      <= '0;
          r_state    <= c_WAIT;
        end
        c_WAIT: begin
          if (!mem_rdy_n) begin
            if (mem_rw) begin
              rdata <= mem_rdata;
            end
            done0       <= gnt0;
            done1       <= gnt1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            mem_data_oe <= 1'b0;
            r_last      <= gnt1;
            r_state     <= c_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
            // Abort in the cycle the counter reaches its limit; the pointer still
            // advances so a dead target cannot starve the other requester.
            if (w_cnt_inc == c_CNT_MAX) begin
              done0       <= gnt0;
              done1       <= gnt1;
              err0        <= gnt0;
              err1        <= gnt1;
              rdata       <= '0;
              gnt0        <= 1'b0;
              gnt1        <= 1'b0;
              mem_data_oe <= 1'b0;
              r_last      <= gnt1;
              r_state     <= c_DONE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, rw0, req1, rw1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_rw, mem_strb_n, mem_data_oe;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdy_n;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.ADDR_SIZE(8), .WORD_SIZE(16), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_strb_n(mem_strb_n),
    .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_rdata(mem_rdata), .mem_rdy_n(mem_rdy_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw_done;
    logic [1:0] order [4];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd1;

    rst_n = 1'b0;
    req0 = 0; rw0 = 1; addr0 = '0; wdata0 = '0;
    req1 = 0; rw1 = 1; addr1 = '0; wdata1 = '0;
    mem_rdata = '0; mem_rdy_n = 1'b1;
    #23;
    chk("rst_strb_n", mem_strb_n, 1);
    chk("rst_oe", mem_data_oe, 0);
    chk("rst_rw", mem_rw, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done_err", {done1, done0, err1, err0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write from requester 0, ready on the second WAIT edge
    req0 = 1; rw0 = 0; addr0 = 8'h05; wdata0 = 16'h1234;
    tick();
    chk("wr_strobe_low", mem_strb_n, 0);
    chk("wr_gnt0", {gnt1, gnt0}, 2'b01);
    chk("wr_addr", mem_addr, 8'h05);
    chk("wr_wdata", mem_wdata, 16'h1234);
    chk("wr_rw", mem_rw, 0);
    chk("wr_oe", mem_data_oe, 1);
    tick();
    chk("wr_strobe_one_cycle", mem_strb_n, 1);
    chk("wr_oe_wait", mem_data_oe, 1);
    tick();
    chk("wr_no_done_first_wait", done0, 0);
    mem_rdy_n = 0;
    tick();
    chk("wr_done0", done0, 1);
    chk("wr_err0", err0, 0);
    chk("wr_gnt_clear", {gnt1, gnt0}, 0);
    chk("wr_oe_clear", mem_data_oe, 0);
    chk("wr_addr_hold", mem_addr, 8'h05);
    chk("wr_rdata_unchanged", rdata, 0);
    req0 = 0; mem_rdy_n = 1;
    tick();
    chk("wr_done_pulse", done0, 0);
    tick();

    // Read from requester 1
    req1 = 1; rw1 = 1; addr1 = 8'h03;
    tick();
    chk("rd_gnt1", {gnt1, gnt0}, 2'b10);
    chk("rd_addr", mem_addr, 8'h03);
    chk("rd_rw", mem_rw, 1);
    chk("rd_oe_strobe", mem_data_oe, 0);
    tick();
    chk("rd_oe_wait", mem_data_oe, 0);
    mem_rdata = 16'hBEEF; mem_rdy_n = 0;
    tick();
    chk("rd_done1", done1, 1);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("rd_oe_done", mem_data_oe, 0);
    req1 = 0; mem_rdy_n = 1; mem_rdata = 16'h0000;
    tick();
    chk("rd_rdata_hold", rdata, 16'hBEEF);
    tick();

    // Timeout: ready never arrives
    req0 = 1; rw0 = 1; addr0 = 8'h07;
    tick();
    tick();
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done0 || err0) saw_done = 1'b1;
    end
    chk("to_no_early_done", saw_done, 0);
    tick();
    chk("to_done0", done0, 1);
    chk("to_err0", err0, 1);
    chk("to_rdata_zero", rdata, 0);
    chk("to_gnt_clear", {gnt1, gnt0}, 0);
    req0 = 0;
    tick();
    chk("to_err_pulse", {done0, err0}, 0);
    tick();
    chk("to_idle_strb", mem_strb_n, 1);

    // Ready asserted only in the STROBE cycle must be ignored
    req1 = 1; rw1 = 0; addr1 = 8'h44; wdata1 = 16'hA5A5;
    tick();
    mem_rdy_n = 0;
    tick();
    mem_rdy_n = 1;
    chk("er_no_done_strobe", done1, 0);
    chk("er_gnt_held", gnt1, 1);
    tick();
    chk("er_no_done_wait", done1, 0);
    mem_rdy_n = 0;
    tick();
    chk("er_done1", {done1, err1}, 2'b10);
    req1 = 0; mem_rdy_n = 1;
    tick();
    tick();

    // Reset in WAIT aborts without a done pulse
    req0 = 1; rw0 = 0; addr0 = 8'h55; wdata0 = 16'h7777;
    tick();
    tick();
    chk("rw_pre_oe", mem_data_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_async_strb", mem_strb_n, 1);
    chk("rw_async_oe", mem_data_oe, 0);
    chk("rw_async_gnt", {gnt1, gnt0}, 0);
    chk("rw_async_addr", mem_addr, 0);
    req0 = 1; rw0 = 0; addr0 = 8'h20; wdata0 = 16'h1111;
    req1 = 1; rw1 = 0; addr1 = 8'h30; wdata1 = 16'h2222;
    mem_rdy_n = 0;
    tick();
    chk("rw_no_done", {done1, done0}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: 0,1,0,1 with idle gaps
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("ct_gnt", {gnt1, gnt0}, (order[t] == 2'd0) ? 2'b01 : 2'b10);
      chk("ct_addr", mem_addr, (order[t] == 2'd0) ? 8'h20 : 8'h30);
      tick();
      chk("ct_gnt_onehot_wait", {gnt1, gnt0}, (order[t] == 2'd0) ? 2'b01 : 2'b10);
      tick();
      chk("ct_done", {done1, done0}, (order[t] == 2'd0) ? 2'b01 : 2'b10);
      chk("ct_idle_gap", {gnt1, gnt0}, 0);
      if (t == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
      chk("ct_idle_state", {gnt1, gnt0, mem_strb_n}, 3'b001);
    end
    mem_rdy_n = 1;
    tick();
    chk("ct_end_idle", {gnt1, gnt0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
